div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the operand, result and iteration width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port valid_i, input, 1: an execute-stage divide/remainder op is present; held high by the pipeline until done_o.
REQ-005 SHALL have port op_i, input, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port word_i, input, 1: W-variant; operands arrive pre-extended from decode (sign-extended for DIV/REM, zero-extended for DIVU/REMU).
REQ-007 SHALL have ports a_i and b_i, input, WIDTH each: dividend and divisor (decode operands rd1/rd2).
REQ-008 SHALL have port flush_i, input, 1: abort any in-flight op.
REQ-009 SHALL have port stall_o, output, 1: pipeline must hold execute.
REQ-010 SHALL have port done_o, output, 1: result_o valid this cycle.
REQ-011 SHALL have port result_o, output, WIDTH: quotient or remainder.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 IDLE with valid_i=1 and flush_i=0: SHALL latch op_i, word_i, operand magnitudes, quotient sign (signed op and sign(a) xor sign(b)), remainder sign (signed op and sign(a)).
REQ-014 On that accept edge, b_i=0 or signed overflow (DIV/REM, a_i=100..0, b_i=all ones) SHALL go directly to DONE with the special result; otherwise SHALL go to BUSY with the iteration counter loaded to WIDTH.
REQ-015 BUSY SHALL perform one restoring shift-subtract step per cycle (partial remainder WIDTH+1 bits, quotient bit shifted in at LSB) and decrement the counter; on the edge where the counter reaches 0, SHALL go to DONE.
REQ-016 A normal op SHALL assert done_o exactly WIDTH+1 cycles after the accept cycle; a special-case op SHALL assert it 1 cycle after.
REQ-017 DONE SHALL drive done_o=1 for exactly one cycle and then go to IDLE unconditionally; valid_i during DONE is not a new request.
REQ-018 Result for a normal op SHALL be the quotient (DIV/DIVU) or remainder (REM/REMU), two's-complement negated when the latched sign is set.
REQ-019 Divide by zero SHALL give quotient all ones and remainder a_i; signed overflow SHALL give quotient a_i and remainder 0.
REQ-020 When word_i is latched, result_o SHALL be bits [31:0] of the computed result sign-extended to WIDTH, covering DIVUW/REMUW too.
REQ-021 result_o SHALL be 0 whenever done_o=0.
REQ-022 stall_o SHALL be combinational: (IDLE and valid_i and not flush_i) or BUSY; 0 in DONE.
REQ-023 flush_i=1 in any state SHALL force IDLE on the next edge and suppress done_o; in IDLE it SHALL block acceptance that cycle.
REQ-024 After a flush, the first new valid_i SHALL be accepted with no dead cycle.

Reset
REQ-025 reset=1 SHALL force IDLE, counter 0, all datapath registers 0 on the next edge, overriding valid_i and flush_i.
REQ-026 While in reset and on the first cycle after, stall_o=0 unless valid_i=1, done_o=0, result_o=0.
REQ-027 reset asserted mid-BUSY SHALL abort the op with no done_o pulse.

Verification
REQ-028 DIVU 100/7 -> done_o at cycle 65 after accept, result 14; REMU same operands -> 2; stall_o high cycles 0..64.
REQ-029 DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF; DIV 7/-2 -> -3; REM 7/-2 -> 1.
REQ-030 DIVU 5/0 -> all ones, done_o 1 cycle after accept; REM 5/0 -> 5; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0.
REQ-031 word_i=1: DIV a=0xFFFF_FFFF_8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000; DIVU a=0x0000_0000_FFFF_FFFF, b=1 -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-032 flush_i pulse on BUSY cycle 20 -> IDLE next cycle, no done_o; DIVU 9/3 issued next cycle -> 3 at cycle 65.
REQ-033 reset pulse on BUSY cycle 30 -> IDLE, outputs 0, no done_o; back-to-back ops with valid_i held -> exactly one done_o each, none re-accepted in DONE.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU/REM/REMU and their W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow finish right after accept.
module div_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [1:0]       op_i,
    input  logic             word_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic             rem_sel, word, q_neg, r_neg;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic             sgn, accept, div_zero, ovf, special;
    logic [WIDTH-1:0] a_mag, b_mag, res, val;
    logic [WIDTH:0]   shl, diff;

    assign sgn      = ~op_i[0];
    assign accept   = state == IDLE && valid_i && !flush_i;
    assign div_zero = b_i == '0;
    assign ovf      = sgn && a_i == {1'b1, {(WIDTH-1){1'b0}}} && &b_i;
    assign special  = div_zero || ovf;
    assign a_mag    = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag    = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;
    // Partial remainder shifted left with the next dividend bit; a clear top bit of diff means it fits.
    assign shl      = {rem, quo[WIDTH-1]};
    assign diff     = shl - {1'b0, dvs};

    always_comb begin
        state_n = flush_i ? IDLE :
                  state == IDLE ? (accept ? (special ? DONE : BUSY) : IDLE) :
                  state == BUSY ? (cnt == CW'(1) ? DONE : BUSY) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            rem_sel <= 1'b0;
            word    <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
        end else if (accept) begin
            rem_sel <= op_i[1];
            word    <= word_i;
            dvs     <= b_mag;
            cnt     <= special ? '0 : CW'(WIDTH);
            q_neg   <= !special && sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            r_neg   <= !special && sgn && a_i[WIDTH-1];
            quo     <= div_zero ? '1 : ovf ? a_i : a_mag;
            rem     <= div_zero ? a_i : '0;
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
            rem <= diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    assign res      = rem_sel ? rem : quo;
    assign val      = (rem_sel ? r_neg : q_neg) ? -res : res;
    assign done_o   = state == DONE && !flush_i && !reset;
    assign result_o = !done_o ? '0 : word ? WIDTH'(signed'(val[31:0])) : val;
    assign stall_o  = !reset && ((state == IDLE && valid_i && !flush_i) || state == BUSY);
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit covering latency, signed/unsigned, specials, W ops, flush and reset.
module tb_div_unit;
    localparam int W = 64;
    localparam logic [W-1:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES = '1;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic         word_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         flush_i = 1'b0;
    logic         stall_o, done_o;
    logic [W-1:0] result_o;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i), .word_i(word_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o),
        .result_o(result_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic w,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        if (b == '0)                                 r = op[1] ? a : ONES;
        else if (!op[0] && a == MIN && b == ONES)    r = op[1] ? '0 : a;
        else if (op[0])                              r = op[1] ? a % b : a / b;
        else r = op[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
        return w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Drives one op from the current cycle (cycle 0) until done_o, then scores it.
    task automatic do_op(input logic [1:0] op, input logic w, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] res, input int lat,
                         input logic keep);
        exp_t e, g;
        int   n = 0;
        logic got = 1'b0;
        logic stall_bad = 1'b0;
        e.res = res;
        e.lat = lat;
        sb.push_back(e);
        op_i = op; word_i = w; a_i = a; b_i = b; valid_i = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            if (done_o) got = 1'b1;
            else begin
                if (stall_o !== 1'b1) stall_bad = 1'b1;
                next_cycle();
                n++;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout op=%0d a=%h b=%h: no done_o within %0d cycles", op, a, b, n);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: done_o with result %h but nothing expected", result_o);
        end else begin
            g = sb.pop_front();
            if (result_o !== g.res) begin
                errors++;
                $display("FAIL result op=%0d w=%0b a=%h b=%h: got %h expected %h", op, w, a, b, result_o, g.res);
            end
            checks++;
            if (n != g.lat) begin
                errors++;
                $display("FAIL latency op=%0d a=%h b=%h: got %0d expected %0d", op, a, b, n, g.lat);
            end
            checks++;
            if (stall_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_at_done: got %b expected 0", stall_o);
            end
            checks++;
            if (stall_bad) begin
                errors++;
                $display("FAIL stall_while_busy: got a low stall_o before done, expected 1");
            end
        end
        next_cycle();
        if (!keep) valid_i = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        valid_i = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if ({stall_o, done_o, result_o} !== {2'b00, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b done=%b res=%h expected 0 0 0", stall_o, done_o, result_o);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall_o, done_o, result_o} !== {2'b00, {W{1'b0}}}) begin
            errors++;
            $display("FAIL post_reset_outputs: got stall=%b done=%b res=%h expected 0 0 0", stall_o, done_o, result_o);
        end
        next_cycle();
    endtask

    task automatic test_unsigned;
        do_op(2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1'b0);
        do_op(2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 65, 1'b0);
    endtask

    task automatic test_signed;
        do_op(2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
        do_op(2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
        do_op(2'b00, 1'b0, 64'd7, -64'sd2, -64'sd3, 65, 1'b0);
        do_op(2'b10, 1'b0, 64'd7, -64'sd2, 64'd1, 65, 1'b0);
    endtask

    task automatic test_special;
        do_op(2'b01, 1'b0, 64'd5, 64'd0, ONES, 1, 1'b0);
        do_op(2'b10, 1'b0, 64'd5, 64'd0, 64'd5, 1, 1'b0);
        do_op(2'b00, 1'b0, MIN, ONES, MIN, 1, 1'b0);
        do_op(2'b10, 1'b0, MIN, ONES, 64'd0, 1, 1'b0);
    endtask

    task automatic test_word;
        do_op(2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 65, 1'b0);
        do_op(2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 65, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            logic [1:0]   op = 2'($urandom_range(0, 3));
            logic         w = 1'($urandom_range(0, 1));
            logic [W-1:0] a = {$urandom(), $urandom()};
            logic [W-1:0] b = (i % 3 == 0) ? W'($urandom_range(1, 1000)) : {$urandom(), $urandom()};
            if (i == 5) b = '0;
            if (w) begin
                a = op[0] ? {32'd0, a[31:0]} : {{32{a[31]}}, a[31:0]};
                b = op[0] ? {32'd0, b[31:0]} : {{32{b[31]}}, b[31:0]};
            end
            do_op(op, w, a, b, model(op, w, a, b),
                  (b == '0 || (!op[0] && a == MIN && b == ONES)) ? 1 : 65, 1'b0);
        end
    endtask

    task automatic test_flush;
        logic spurious = 1'b0;
        op_i = 2'b01; word_i = 1'b0; a_i = 64'd100; b_i = 64'd7; valid_i = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            if (n == 20) flush_i = 1'b1;
            @(negedge clk);
            if (done_o) spurious = 1'b1;
            next_cycle();
        end
        flush_i = 1'b0;
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL flush_no_done: got done_o during flushed op, expected none");
        end
        do_op(2'b01, 1'b0, 64'd9, 64'd3, 64'd3, 65, 1'b0);
        flush_i = 1'b1;
        valid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_accept: got stall=%b expected 0", stall_o);
        end
        next_cycle();
        flush_i = 1'b0;
        do_op(2'b11, 1'b0, 64'd50, 64'd8, 64'd2, 65, 1'b0);
    endtask

    task automatic test_reset_mid;
        logic bad = 1'b0;
        op_i = 2'b01; word_i = 1'b0; a_i = 64'd100; b_i = 64'd7; valid_i = 1'b1;
        repeat (30) next_cycle();
        reset = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall_o, done_o, result_o} !== {2'b00, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid_busy: got stall=%b done=%b res=%h expected 0 0 0", stall_o, done_o, result_o);
        end
        next_cycle();
        reset = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done_o || stall_o || result_o != '0) bad = 1'b1;
            next_cycle();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_abort_quiet: got activity after mid-op reset, expected idle outputs");
        end
        do_op(2'b10, 1'b0, -64'sd7, 64'd2, ONES, 65, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic extra = 1'b0;
        do_op(2'b01, 1'b0, 64'd1000, 64'd10, 64'd100, 65, 1'b1);
        do_op(2'b01, 1'b0, 64'd77, 64'd0, ONES, 1, 1'b1);
        do_op(2'b00, 1'b0, -64'sd100, 64'd9, -64'sd11, 65, 1'b1);
        do_op(2'b11, 1'b0, 64'd100, 64'd9, 64'd1, 65, 1'b0);
        repeat (70) begin
            @(negedge clk);
            if (done_o) extra = 1'b1;
            next_cycle();
        end
        checks++;
        if (extra || sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_extra: got extra done=%b pending=%0d expected 0 0", extra, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_word();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
